// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - shared decimal converter link between scan controller and converter
interface display_scan_ctrl_if;
    logic [6:0] conv_n;
    logic       conv_lz;
    logic [3:0] conv_ten;
    logic [3:0] conv_one;

    modport master (
        output conv_n,
        output conv_lz,
        input  conv_ten,
        input  conv_one
    );

    modport slave (
        input  conv_n,
        input  conv_lz,
        output conv_ten,
        output conv_one
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit multiplexed seven-segment scan controller with shared converter
module display_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 62
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            val0,
    input  logic [6:0]            val1,
    input  logic                  lz0,
    input  logic                  lz1,
    input  logic [1:0]            blink_en,
    display_scan_ctrl_if.master   conv,
    output logic [3:0]            an,
    output logic [3:0]            digit,
    output logic                  frame_start
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [1:0] S_SNAP  = 2'd0;
    localparam logic [1:0] S_CONV0 = 2'd1;
    localparam logic [1:0] S_CONV1 = 2'd2;
    localparam logic [1:0] S_SHOW  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [FRM_W-1:0] frm;
    logic             blink_phase;
    logic [6:0]       snap_val0;
    logic [6:0]       snap_val1;
    logic             snap_lz0;
    logic             snap_lz1;
    logic [1:0]       snap_blink;
    logic [3:0]       dbuf [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_SNAP;
            idx         <= 2'd0;
            cnt         <= '0;
            frm         <= '0;
            blink_phase <= 1'b0;
            snap_val0   <= 7'd0;
            snap_val1   <= 7'd0;
            snap_lz0    <= 1'b0;
            snap_lz1    <= 1'b0;
            snap_blink  <= 2'd0;
            dbuf[0]     <= 4'd10;
            dbuf[1]     <= 4'd10;
            dbuf[2]     <= 4'd10;
            dbuf[3]     <= 4'd10;
        end else begin
            case (state)
                S_SNAP: begin
                    snap_val0  <= val0;
                    snap_val1  <= val1;
                    snap_lz0   <= lz0;
                    snap_lz1   <= lz1;
                    snap_blink <= blink_en;
                    state      <= S_CONV0;
                end
                S_CONV0: begin
                    dbuf[0] <= conv.conv_one;
                    dbuf[1] <= conv.conv_ten;
                    state   <= S_CONV1;
                end
                S_CONV1: begin
                    dbuf[2] <= conv.conv_one;
                    dbuf[3] <= conv.conv_ten;
                    idx     <= 2'd0;
                    cnt     <= '0;
                    state   <= S_SHOW;
                end
                S_SHOW: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (idx == 2'd3) begin
                            idx   <= 2'd0;
                            state <= S_SNAP;
                            // blink_phase only flips at a frame boundary so a frame never tears
                            if (frm == FRM_LAST) begin
                                frm         <= '0;
                                blink_phase <= ~blink_phase;
                            end else begin
                                frm <= frm + FRM_W'(1);
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_SNAP;
            endcase
        end
    end

    always_comb begin
        conv.conv_n  = 7'd0;
        conv.conv_lz = 1'b0;
        an           = 4'hF;
        digit        = 4'd10;
        frame_start  = 1'b0;
        case (state)
            S_SNAP:  frame_start = 1'b1;
            S_CONV0: begin
                conv.conv_n  = snap_val0;
                conv.conv_lz = snap_lz0;
            end
            S_CONV1: begin
                conv.conv_n  = snap_val1;
                conv.conv_lz = snap_lz1;
            end
            S_SHOW: begin
                // digit stays valid through the anti-ghost gap so the decoder settles before the anode opens
                if (cnt >= BLANK_END)
                    an = ~(4'b0001 << idx);
                digit = (snap_blink[idx[1]] && blink_phase) ? 4'd10 : dbuf[idx];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl against a frame-level model
module tb_display_scan_ctrl;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BF = 2;
    localparam int FL = 3 + 4 * SD;

    typedef struct packed {
        logic [6:0] v0;
        logic [6:0] v1;
        logic       z0;
        logic       z1;
        logic [1:0] bl;
    } in_t;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] digit;
        logic       fs;
        logic [6:0] n;
        logic       lz;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] val0 = 7'd0;
    logic [6:0] val1 = 7'd0;
    logic       lz0 = 1'b0;
    logic       lz1 = 1'b0;
    logic [1:0] blink_en = 2'd0;
    logic [3:0] an;
    logic [3:0] digit;
    logic       frame_start;

    int   checks = 0;
    int   failures = 0;
    int   f = 0;
    in_t  cur;
    in_t  snap;
    obs_t obs;
    obs_t exp_o;

    always #5 clk = ~clk;

    display_scan_ctrl_if cif();

    display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .reset       (reset),
        .val0        (val0),
        .val1        (val1),
        .lz0         (lz0),
        .lz1         (lz1),
        .blink_en    (blink_en),
        .conv        (cif.master),
        .an          (an),
        .digit       (digit),
        .frame_start (frame_start)
    );

    // Decimal converter: {ten, one}; 10 = blank, 15 = error for anything above 99
    function automatic logic [7:0] conv(input logic [6:0] n, input logic lz);
        int tn;
        int on;
        if (n > 7'd99) return 8'hFF;
        tn = int'(n) / 10;
        on = int'(n) % 10;
        if (lz && tn == 0) begin
            tn = 10;
            if (on == 0) on = 10;
        end
        return {tn[3:0], on[3:0]};
    endfunction

    assign {cif.conv_ten, cif.conv_one} = conv(cif.conv_n, cif.conv_lz);

    function automatic obs_t model(input int t, input int fr, input in_t s);
        obs_t       e;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [3:0] d [4];
        int         slot;
        int         pos;
        e.an = 4'hF; e.digit = 4'd10; e.fs = 1'b0; e.n = 7'd0; e.lz = 1'b0;
        if (t == 0) e.fs = 1'b1;
        else if (t == 1) begin e.n = s.v0; e.lz = s.z0; end
        else if (t == 2) begin e.n = s.v1; e.lz = s.z1; end
        else begin
            slot = (t - 3) / SD;
            pos  = (t - 3) % SD;
            c0 = conv(s.v0, s.z0);
            c1 = conv(s.v1, s.z1);
            d[0] = c0[3:0]; d[1] = c0[7:4]; d[2] = c1[3:0]; d[3] = c1[7:4];
            if (pos >= BC) e.an[slot] = 1'b0;
            e.digit = (s.bl[slot / 2] && ((fr / BF) % 2 == 1)) ? 4'd10 : d[slot];
        end
        return e;
    endfunction

    function automatic obs_t sample();
        return {an, digit, frame_start, cif.conv_n, cif.conv_lz};
    endfunction

    function automatic in_t rand_in();
        in_t s;
        int  r;
        r = int'($urandom_range(0, 9));
        s.v0 = (r < 7) ? 7'($urandom_range(0, 99)) : (r < 9) ? 7'd127 : 7'($urandom_range(100, 126));
        s.v1 = 7'($urandom_range(0, 127));
        s.z0 = 1'($urandom_range(0, 1));
        s.z1 = 1'($urandom_range(0, 1));
        s.bl = 2'($urandom_range(0, 3));
        return s;
    endfunction

    task automatic drive(input in_t s);
        val0 = s.v0; val1 = s.v1; lz0 = s.z0; lz1 = s.z1; blink_en = s.bl;
    endtask

    // Leaves the bench at the falling edge inside cycle 0 of a fresh frame
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        f = 0;
    endtask

    task automatic test_reset();
        cur = rand_in();
        drive(cur);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        obs = sample();
        checks++;
        if (obs.an !== 4'hF || obs.digit !== 4'd10 || obs.n !== 7'd0) begin
            failures++;
            $display("FAIL reset_hold got an=%h digit=%0d n=%0d exp an=f digit=10 n=0", obs.an, obs.digit, obs.n);
        end
        reset = 1'b0;
        obs = sample();
        checks++;
        if (obs.fs !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_fs got=%b exp=1", obs.fs);
        end
    endtask

    task automatic test_basic_scan();
        cur = '{v0: 7'd42, v1: 7'd7, z0: 1'b1, z1: 1'b1, bl: 2'b00};
        drive(cur);
        do_reset();
        for (int fr = 0; fr < 2; fr++) begin
            for (int t = 0; t < FL; t++) begin
                if (t == 0) snap = cur;
                obs = sample();
                exp_o = model(t, f, snap);
                checks++;
                if (obs !== exp_o) begin
                    failures++;
                    $display("FAIL basic_scan t=%0d frame=%0d got=%h exp=%h", t, f, obs, exp_o);
                end
                @(negedge clk);
            end
            f++;
        end
    endtask

    task automatic test_leading_zero_error();
        in_t tbl [4];
        tbl[0] = '{v0: 7'd127, v1: 7'd0, z0: 1'b0, z1: 1'b1, bl: 2'b00};
        tbl[1] = '{v0: 7'd127, v1: 7'd0, z0: 1'b1, z1: 1'b0, bl: 2'b00};
        tbl[2] = '{v0: 7'd5,   v1: 7'd99, z0: 1'b0, z1: 1'b1, bl: 2'b00};
        tbl[3] = '{v0: 7'd110, v1: 7'd10, z0: 1'b1, z1: 1'b1, bl: 2'b00};
        cur = tbl[0];
        drive(cur);
        do_reset();
        for (int fr = 0; fr < 4; fr++) begin
            for (int t = 0; t < FL; t++) begin
                if (t == 0) begin cur = tbl[fr]; drive(cur); snap = cur; end
                obs = sample();
                exp_o = model(t, f, snap);
                checks++;
                if (obs !== exp_o) begin
                    failures++;
                    $display("FAIL lz_error t=%0d frame=%0d got=%h exp=%h", t, f, obs, exp_o);
                end
                @(negedge clk);
            end
            f++;
        end
    endtask

    task automatic test_mid_frame_change();
        cur = '{v0: 7'd42, v1: 7'd7, z0: 1'b1, z1: 1'b1, bl: 2'b00};
        drive(cur);
        do_reset();
        for (int fr = 0; fr < 2; fr++) begin
            for (int t = 0; t < FL; t++) begin
                if (t == 0) snap = cur;
                if (fr == 0 && t == 8) begin cur.v0 = 7'd99; drive(cur); end
                obs = sample();
                exp_o = model(t, f, snap);
                checks++;
                if (obs !== exp_o) begin
                    failures++;
                    $display("FAIL mid_frame t=%0d frame=%0d got=%h exp=%h", t, f, obs, exp_o);
                end
                @(negedge clk);
            end
            f++;
        end
    endtask

    task automatic test_blink();
        cur = '{v0: 7'd42, v1: 7'd7, z0: 1'b1, z1: 1'b0, bl: 2'b01};
        drive(cur);
        do_reset();
        for (int fr = 0; fr < 5; fr++) begin
            for (int t = 0; t < FL; t++) begin
                if (t == 0) snap = cur;
                obs = sample();
                exp_o = model(t, f, snap);
                checks++;
                if (obs !== exp_o) begin
                    failures++;
                    $display("FAIL blink t=%0d frame=%0d got=%h exp=%h", t, f, obs, exp_o);
                end
                @(negedge clk);
            end
            f++;
        end
    endtask

    task automatic test_reset_mid_show();
        cur = '{v0: 7'd42, v1: 7'd7, z0: 1'b1, z1: 1'b1, bl: 2'b10};
        drive(cur);
        do_reset();
        snap = cur;
        for (int t = 0; t < 10; t++) begin
            obs = sample();
            exp_o = model(t, f, snap);
            checks++;
            if (obs !== exp_o) begin
                failures++;
                $display("FAIL pre_reset t=%0d got=%h exp=%h", t, obs, exp_o);
            end
            if (t == 9) reset = 1'b1;
            @(negedge clk);
        end
        obs = sample();
        checks++;
        if (obs.an !== 4'hF || obs.digit !== 4'd10) begin
            failures++;
            $display("FAIL mid_show_reset got an=%h digit=%0d exp an=f digit=10", obs.an, obs.digit);
        end
        @(negedge clk);
        reset = 1'b0;
        f = 0;
        for (int t = 0; t < FL + 1; t++) begin
            obs = sample();
            exp_o = model(t % FL, f, snap);
            checks++;
            if (obs !== exp_o) begin
                failures++;
                $display("FAIL post_reset t=%0d got=%h exp=%h", t, obs, exp_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int chg;
        cur = rand_in();
        drive(cur);
        do_reset();
        for (int fr = 0; fr < 12; fr++) begin
            chg = int'($urandom_range(1, FL - 1));
            for (int t = 0; t < FL; t++) begin
                if (t == 0) begin cur = rand_in(); drive(cur); snap = cur; end
                if (t == chg) begin cur = rand_in(); drive(cur); end
                obs = sample();
                exp_o = model(t, f, snap);
                checks++;
                if (obs !== exp_o) begin
                    failures++;
                    $display("FAIL random t=%0d frame=%0d got=%h exp=%h", t, f, obs, exp_o);
                end
                @(negedge clk);
            end
            f++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_leading_zero_error();
        test_mid_frame_change();
        test_blink();
        test_reset_mid_show();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
